// File: rtl/jump_pkg.sv
// Shared state encoding, limits and default physics constants for the jump trajectory stage.
package jump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_FLY    = 2'd2,
    ST_DONE   = 2'd3
  } jump_state_e;

  localparam int V_MAX            = 127;
  localparam int GRAVITY_DEF      = 1;
  localparam int HEIGHT_SHIFT_DEF = 5;
  localparam int DIST_SHIFT_DEF   = 7;

  function automatic logic [6:0] sat_v(input logic [10:0] v_in);
    return (v_in > 11'(V_MAX)) ? 7'(V_MAX) : v_in[6:0];
  endfunction

endpackage

// File: rtl/jump_tick_gen.sv
// Physics tick divider: modulo-TICK_DIV counter, 1-cycle tick on the terminal count.
module jump_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk_machine,
  input  logic rst_machine,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(TICK_DIV - 1));
  assign tick_o = en_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jump_trajectory.sv
// Ballistic jump integrator: height/distance accumulators advanced once per physics tick.
//   state  | meaning
//   IDLE   | waiting for i_jump_en, latches saturated velocity
//   LAUNCH | one cycle, seeds vy and clears accumulators/outputs
//   FLY    | integrates on each tick until the arc lands or the jump aborts
//   DONE   | landed, holds done/dist until i_jump_en drops
module jump_trajectory
  import jump_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int GRAVITY      = GRAVITY_DEF,
  parameter int HEIGHT_SHIFT = HEIGHT_SHIFT_DEF,
  parameter int DIST_SHIFT   = DIST_SHIFT_DEF
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic        i_jump_en,
  input  logic [10:0] i_v_init,
  output logic        o_jump_done,
  output logic [8:0]  o_jump_height,
  output logic [10:0] o_jump_dist
);

  jump_state_e        state_q, state_d;
  logic [6:0]         v_q, v_d;
  logic signed [8:0]  vy_q, vy_d;
  logic signed [14:0] h_acc_q, h_acc_d;
  logic [15:0]        d_acc_q, d_acc_d;
  logic               done_q, done_d;
  logic [8:0]         height_q, height_d;
  logic [10:0]        dist_q, dist_d;

  logic               tick;
  logic signed [15:0] nh;
  logic [15:0]        d_sum;

  jump_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .clr_i       (state_q == ST_LAUNCH),
    .en_i        (state_q == ST_FLY),
    .tick_o      (tick)
  );

  assign nh    = {h_acc_q[14], h_acc_q} + {{7{vy_q[8]}}, vy_q};
  assign d_sum = d_acc_q + {9'd0, v_q};

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    vy_d     = vy_q;
    h_acc_d  = h_acc_q;
    d_acc_d  = d_acc_q;
    done_d   = done_q;
    height_d = height_q;
    dist_d   = dist_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_jump_en) begin
          state_d = ST_LAUNCH;
          v_d     = sat_v(i_v_init);
        end
      end
      ST_LAUNCH: begin
        height_d = '0;
        dist_d   = '0;
        if (!i_jump_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLY;
          vy_d    = {2'b00, v_q};
          h_acc_d = '0;
          d_acc_d = '0;
        end
      end
      ST_FLY: begin
        if (!i_jump_en) begin
          state_d  = ST_IDLE;
          height_d = '0;
          dist_d   = '0;
        end else if (tick) begin
          d_acc_d = d_sum;
          dist_d  = 11'(d_sum >> DIST_SHIFT);
          // Landing is detected on the tick whose step would reach or cross the ground.
          if (nh <= 16'sd0) begin
            h_acc_d  = '0;
            height_d = '0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            h_acc_d  = nh[14:0];
            height_d = 9'(nh[14:0] >> HEIGHT_SHIFT);
            vy_d     = vy_q - 9'(GRAVITY);
          end
        end
      end
      ST_DONE: begin
        height_d = '0;
        if (!i_jump_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      state_q  <= ST_IDLE;
      v_q      <= '0;
      vy_q     <= '0;
      h_acc_q  <= '0;
      d_acc_q  <= '0;
      done_q   <= 1'b0;
      height_q <= '0;
      dist_q   <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      vy_q     <= vy_d;
      h_acc_q  <= h_acc_d;
      d_acc_q  <= d_acc_d;
      done_q   <= done_d;
      height_q <= height_d;
      dist_q   <= dist_d;
    end
  end

  assign o_jump_done   = done_q;
  assign o_jump_height = height_q;
  assign o_jump_dist   = dist_q;

endmodule

// File: tb/tb_jump_trajectory.sv
// Scoreboard bench for jump_trajectory: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_jump_trajectory;

  logic        clk_machine = 1'b0;
  logic        rst_machine = 1'b1;
  logic        i_jump_en   = 1'b0;
  logic [10:0] i_v_init    = '0;
  logic        o_jump_done;
  logic [8:0]  o_jump_height;
  logic [10:0] o_jump_dist;

  jump_trajectory #(.TICK_DIV(4)) dut (
    .clk_machine   (clk_machine),
    .rst_machine   (rst_machine),
    .i_jump_en     (i_jump_en),
    .i_v_init      (i_v_init),
    .o_jump_done   (o_jump_done),
    .o_jump_height (o_jump_height),
    .o_jump_dist   (o_jump_dist)
  );

  always #5 clk_machine = ~clk_machine;

  int cyc = 0;
  always @(posedge clk_machine) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string name;
    bit    done;
    int    h;
    int    d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_out(input string nm, input bit dn, input int h, input int d);
    n_cmp++;
    if (o_jump_done !== dn || int'(o_jump_height) != h || int'(o_jump_dist) != d
        || $isunknown({o_jump_done, o_jump_height, o_jump_dist})) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got done=%0b h=%0d d=%0d, expected done=%0b h=%0d d=%0d",
               nm, cyc, o_jump_done, o_jump_height, o_jump_dist, dn, h, d);
    end
  endtask

  task automatic expect_at(input int c, input string nm, input bit dn, input int h, input int d);
    exp_t e;
    e.cyc = c; e.name = nm; e.done = dn; e.h = h; e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk_machine) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: expectation for cyc %0d reached monitor at cyc %0d", e.name, e.cyc, cyc);
      end else begin
        check_out(e.name, e.done, e.h, e.d);
      end
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk_machine);
    #1;
  endtask

  task automatic launch(input int v, output int base);
    i_v_init  = 11'(v);
    i_jump_en = 1'b1;
    base      = cyc + 2;
  endtask

  initial begin
    int b;

    repeat (3) @(negedge clk_machine);
    #1;
    check_out("reset", 0, 0, 0);
    rst_machine = 1'b0;
    expect_at(cyc + 2, "idle", 0, 0, 0);

    // v=127 held high; velocity input changes after latch must be ignored
    step_to(cyc + 3);
    launch(127, b);
    expect_at(b,        "v127_fly0",  0, 0,   0);
    expect_at(b + 508,  "v127_t127",  0, 254, 126);
    expect_at(b + 510,  "v127_hold",  0, 254, 126);
    expect_at(b + 512,  "v127_t128",  0, 254, 127);
    expect_at(b + 1016, "v127_t254",  0, 3,   252);
    expect_at(b + 1020, "v127_done",  1, 0,   253);
    expect_at(b + 1030, "v127_en_hi", 1, 0,   253);
    step_to(b + 1);
    i_v_init = 11'd5;
    step_to(b + 1030);
    i_jump_en = 1'b0;
    expect_at(b + 1031, "v127_clr", 0, 0, 253);

    // v=1
    step_to(cyc + 2);
    launch(1, b);
    expect_at(b - 1,  "launch_dist_hold", 0, 0, 253);
    expect_at(b + 4,  "v1_t1",   0, 0, 0);
    expect_at(b + 8,  "v1_t2",   0, 0, 0);
    expect_at(b + 11, "v1_pre",  0, 0, 0);
    expect_at(b + 12, "v1_done", 1, 0, 0);
    step_to(b + 12);
    i_jump_en = 1'b0;
    expect_at(b + 13, "v1_clr", 0, 0, 0);

    // v=0
    step_to(cyc + 2);
    launch(0, b);
    expect_at(b + 3, "v0_pre",  0, 0, 0);
    expect_at(b + 4, "v0_done", 1, 0, 0);
    expect_at(b + 6, "v0_hold", 1, 0, 0);
    step_to(b + 6);
    i_jump_en = 1'b0;
    expect_at(b + 7, "v0_clr", 0, 0, 0);

    // v=500 saturates to 127
    step_to(cyc + 2);
    launch(500, b);
    expect_at(b + 508,  "v500_t127", 0, 254, 126);
    expect_at(b + 1016, "v500_t254", 0, 3,   252);
    expect_at(b + 1020, "v500_done", 1, 0,   253);
    step_to(b + 1020);
    i_jump_en = 1'b0;
    expect_at(b + 1021, "v500_clr", 0, 0, 253);

    // abort at tick 50
    step_to(cyc + 2);
    launch(127, b);
    expect_at(b - 1,   "abort_launch", 0, 0,   253);
    expect_at(b,       "abort_fly0",   0, 0,   0);
    expect_at(b + 200, "abort_t50",    0, 160, 49);
    step_to(b + 200);
    i_jump_en = 1'b0;
    expect_at(b + 201, "abort_idle",  0, 0, 0);
    expect_at(b + 260, "abort_quiet", 0, 0, 0);

    // asynchronous reset mid-flight
    step_to(b + 262);
    launch(127, b);
    expect_at(b + 100, "rst_t25", 0, 89, 24);
    step_to(b + 100);
    #2;
    rst_machine = 1'b1;
    #1;
    check_out("rst_async", 0, 0, 0);
    i_jump_en = 1'b0;
    expect_at(cyc + 1, "rst_held", 0, 0, 0);
    step_to(cyc + 3);
    rst_machine = 1'b0;

    // v=2 after reset
    step_to(cyc + 2);
    launch(2, b);
    expect_at(b + 16, "v2_t4",   0, 0, 0);
    expect_at(b + 20, "v2_done", 1, 0, 0);
    step_to(b + 20);
    i_jump_en = 1'b0;
    expect_at(b + 21, "v2_clr", 0, 0, 0);

    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk_machine);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s: expectation for cyc %0d never checked", e.name, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
